// File: rtl/m_dac_spi.sv
// SPI serializer for the waveform DAC: takes one word over VALID/READY and shifts it
// MSB-first as a SYNC-framed burst on a divided SCLK, then holds an idle gap.
module m_dac_spi #(
  parameter int DIV   = 8,
  parameter int WIDTH = 16,
  parameter int GAP   = 4
) (
  input  logic             CLK30,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             SCLK,
  output logic             SDIN,
  output logic             SYNC,
  output logic             DONE
);

  localparam int HW   = $clog2(DIV + 1);
  localparam int BW   = $clog2(WIDTH);
  localparam int GCNT = 2 * GAP * DIV;
  localparam int GW   = $clog2(GCNT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    h_q, h_d;
  logic [BW-1:0]    b_q, b_d;
  logic [GW-1:0]    g_q, g_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic             sclk_q, sclk_d;
  logic             sdin_q, sdin_d;
  logic             sync_q, sync_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    b_d     = b_q;
    g_d     = g_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    sync_d  = sync_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        sclk_d  = 1'b1;
        sync_d  = 1'b1;
        sdin_d  = 1'b0;
        if (VALID && ready_q) begin
          // MSB goes straight to SDIN; the remaining bits wait in the shifter
          shift_d = DATA[WIDTH-2:0];
          sdin_d  = DATA[WIDTH-1];
          sync_d  = 1'b0;
          ready_d = 1'b0;
          h_d     = '0;
          b_d     = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sync_d = 1'b0;
        if (h_q == HW'(DIV - 1)) begin
          h_d    = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (b_q == BW'(WIDTH - 1)) begin
              sync_d  = 1'b1;
              sclk_d  = 1'b1;
              sdin_d  = 1'b0;
              done_d  = 1'b1;
              g_d     = '0;
              state_d = S_GAP;
            end else begin
              b_d     = b_q + 1'b1;
              sdin_d  = shift_q[WIDTH-2];
              shift_d = {shift_q[WIDTH-3:0], 1'b0};
            end
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      S_GAP: begin
        sync_d = 1'b1;
        sclk_d = 1'b1;
        sdin_d = 1'b0;
        if (g_q == GW'(GCNT - 1)) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK30) begin
    if (RST) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      sclk_q  <= 1'b1;
      sdin_q  <= 1'b0;
      sync_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      b_q     <= b_d;
      g_q     <= g_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      sync_q  <= sync_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Sample payload needs no reset: it is always reloaded before use
  always_ff @(posedge CLK30) begin
    shift_q <= shift_d;
  end

  assign READY = ready_q;
  assign SCLK  = sclk_q;
  assign SDIN  = sdin_q;
  assign SYNC  = sync_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_m_dac_spi.sv
// Directed bench for m_dac_spi: default instance plus a DIV=1/WIDTH=8/GAP=1 corner instance.
module tb_m_dac_spi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] data;
  logic        valid;
  logic        ready, sclk, sdin, sync, done;
  logic [7:0]  c_data;
  logic        c_valid;
  logic        c_ready, c_sclk, c_sdin, c_sync, c_done;

  m_dac_spi #(.DIV(8), .WIDTH(16), .GAP(4)) u_dut (
    .CLK30(clk), .RST(rst), .DATA(data), .VALID(valid), .READY(ready),
    .SCLK(sclk), .SDIN(sdin), .SYNC(sync), .DONE(done)
  );

  m_dac_spi #(.DIV(1), .WIDTH(8), .GAP(1)) u_cor (
    .CLK30(clk), .RST(rst), .DATA(c_data), .VALID(c_valid), .READY(c_ready),
    .SCLK(c_sclk), .SDIN(c_sdin), .SYNC(c_sync), .DONE(c_done)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  int          sync_first, sync_last, sync_cnt, sync_falls, fall_cnt;
  int          done_cnt, done_cyc, ready_cyc, acc2_cyc, tog_cnt;
  int          fall_cyc[$];
  logic [63:0] cap;
  logic [4:0]  snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    sync_first = -1; sync_last = -1; sync_cnt = 0; sync_falls = 0; fall_cnt = 0;
    done_cnt = 0; done_cyc = -1; ready_cyc = -1; acc2_cyc = -1; tog_cnt = 0;
    fall_cyc.delete();
    cap  = '0;
    snap = 'x;
  endtask

  // Waits (bounded) for READY in the current cycle, then presents the word.
  task automatic accept16(input logic [15:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 64'(ready), 64'd1);
    valid = 1'b1;
    data  = d;
  endtask

  // Cycle c=1 is the first cycle after the accept cycle.
  task automatic watch(input int n, input int off_at,
                       input int tog_at, input logic [15:0] tog_val,
                       input int tog2_at, input logic [15:0] tog2_val,
                       input int busy_at, input int rst_at, input int snap_at);
    logic ps, py;
    clear_mon();
    ps = sclk;
    py = sync;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!sync) begin
        sync_cnt++;
        if (sync_first < 0) sync_first = c;
        sync_last = c;
      end
      if (py && !sync) sync_falls++;
      if (ps && !sclk) begin
        fall_cnt++;
        fall_cyc.push_back(c);
        cap = {cap[62:0], sdin};
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (ready && ready_cyc < 0) ready_cyc = c;
      if (c == snap_at) snap = {ready, sclk, sync, sdin, done};
      ps = sclk;
      py = sync;
      if (c == off_at) valid = 1'b0;
      if (c == tog_at) data = tog_val;
      if (c == tog2_at) data = tog2_val;
      if (busy_at > 0 && c == busy_at) begin
        valid = 1'b1;
        data  = 16'hDEAD;
      end
      if (busy_at > 0 && c == busy_at + 1) valid = 1'b0;
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 5) rst = 1'b0;
      if (ready && valid && acc2_cyc < 0) acc2_cyc = c;
    end
  endtask

  initial begin
    logic ps;
    rst = 1'b1; valid = 1'b0; data = '0; c_valid = 1'b0; c_data = '0;
    clear_mon();

    // reset: five cycles held, idle values throughout, READY one cycle after release
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_outputs", 64'({ready, sclk, sync, sdin, done}), 64'(5'b01100));
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 64'(ready), 64'd1);
    chk("cor_ready_after_release", 64'(c_ready), 64'd1);

    // single frame A55A
    accept16(16'hA55A);
    watch(330, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    chk("single_sync_first", 64'(sync_first), 64'd1);
    chk("single_sync_last", 64'(sync_last), 64'd256);
    chk("single_sync_cnt", 64'(sync_cnt), 64'd256);
    chk("single_fall_cnt", 64'(fall_cnt), 64'd16);
    for (int k = 0; k < 16 && k < fall_cyc.size(); k++)
      chk("single_fall_cyc", 64'(fall_cyc[k]), 64'(9 + 16 * k));
    chk("single_capture", cap, 64'h0000_0000_0000_A55A);
    chk("single_done_cnt", 64'(done_cnt), 64'd1);
    chk("single_done_cyc", 64'(done_cyc), 64'd257);
    chk("single_ready_cyc", 64'(ready_cyc), 64'd321);

    // back-to-back with VALID held; DATA changes mid-frame must not leak in
    accept16(16'h0001);
    watch(650, 330, 100, 16'h1234, 300, 16'hFFFF, 0, 0, 0);
    chk("b2b_second_accept", 64'(acc2_cyc), 64'd321);
    chk("b2b_sync_frames", 64'(sync_falls), 64'd2);
    chk("b2b_fall_cnt", 64'(fall_cnt), 64'd32);
    chk("b2b_capture", cap, 64'h0000_0000_0001_FFFF);
    chk("b2b_done_cnt", 64'(done_cnt), 64'd2);

    // busy-ignore: VALID pulsed with DEAD mid-frame
    accept16(16'h3C96);
    watch(400, 1, 0, 16'h0, 0, 16'h0, 50, 0, 0);
    chk("busy_sync_frames", 64'(sync_falls), 64'd1);
    chk("busy_fall_cnt", 64'(fall_cnt), 64'd16);
    chk("busy_capture", cap, 64'h0000_0000_0000_3C96);
    chk("busy_done_cnt", 64'(done_cnt), 64'd1);

    // reset mid-frame at t+100, released five cycles later
    accept16(16'hF00F);
    watch(110, 1, 0, 16'h0, 0, 16'h0, 0, 100, 101);
    chk("abort_snapshot", 64'(snap), 64'(5'b01100));
    chk("abort_sync_last", 64'(sync_last), 64'd100);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_ready_cyc", 64'(ready_cyc), 64'd106);
    accept16(16'h5A3C);
    watch(330, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    chk("after_abort_capture", cap, 64'h0000_0000_0000_5A3C);
    chk("after_abort_fall_cnt", 64'(fall_cnt), 64'd16);
    chk("after_abort_done_cyc", 64'(done_cyc), 64'd257);

    // parameter corner DIV=1 WIDTH=8 GAP=1 with word 81
    @(negedge clk);
    chk("cor_accept_ready", 64'(c_ready), 64'd1);
    c_valid = 1'b1;
    c_data  = 8'h81;
    clear_mon();
    ps = c_sclk;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (!c_sync) begin
        sync_cnt++;
        if (sync_first < 0) sync_first = c;
        sync_last = c;
      end
      if (ps != c_sclk) tog_cnt++;
      if (ps && !c_sclk) begin
        fall_cnt++;
        fall_cyc.push_back(c);
        cap = {cap[62:0], c_sdin};
      end
      if (c_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c_ready && ready_cyc < 0) ready_cyc = c;
      ps = c_sclk;
      if (c == 1) begin
        c_valid = 1'b0;
        c_data  = 8'h00;
      end
    end
    chk("cor_sync_first", 64'(sync_first), 64'd1);
    chk("cor_sync_cnt", 64'(sync_cnt), 64'd16);
    chk("cor_sclk_toggles", 64'(tog_cnt), 64'd16);
    chk("cor_fall_cnt", 64'(fall_cnt), 64'd8);
    for (int k = 0; k < 8 && k < fall_cyc.size(); k++)
      chk("cor_fall_cyc", 64'(fall_cyc[k]), 64'(2 + 2 * k));
    chk("cor_capture", cap, 64'h0000_0000_0000_0081);
    chk("cor_done_cyc", 64'(done_cyc), 64'd17);
    chk("cor_done_cnt", 64'(done_cnt), 64'd1);
    chk("cor_ready_cyc", 64'(ready_cyc), 64'd19);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
